// File: rtl/tmds_channel_encoder_if.sv
// Video-side bundle for one TMDS channel: pixel/control inputs toward the
// encoder and the encoded symbol plus aligned data-enable back out.
interface tmds_channel_encoder_if;
   logic       de;
   logic [7:0] din;
   logic [1:0] ctrl;
   logic [9:0] tmds;
   logic       de_out;

   // Pixel/timing generator side: drives the video stream, receives symbols.
   modport master (
      output de,
      output din,
      output ctrl,
      input  tmds,
      input  de_out
   );

   // Encoder side.
   modport slave (
      input  de,
      input  din,
      input  ctrl,
      output tmds,
      output de_out
   );
endinterface

// File: rtl/tmds_channel_encoder.sv
// Per-channel 8b/10b TMDS encoder (DVI 1.0 style).
// Stage 1 does transition minimisation, stage 2 does DC balancing with a
// running disparity counter, followed by LATENCY_ALIGN plain delay stages.
module tmds_channel_encoder #(
   parameter int unsigned LATENCY_ALIGN = 0
) (
   input  logic                 sysclk,
   input  logic                 rst,
   tmds_channel_encoder_if.slave link
);

   localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

   // Stage-2 symbol selection
   typedef enum logic [1:0] {
      MODE_CTRL,   // control period token
      MODE_BAL,    // cnt==0 or balanced q_m: polarity chosen by q_m[8]
      MODE_INV,    // invert data bits to pull disparity back toward zero
      MODE_PASS    // send data bits as-is
   } mode_t;

   // ---------------------------------------------------------------------
   // Stage 1: transition minimisation
   // ---------------------------------------------------------------------
   logic [3:0] n1d;
   logic       use_xnor;
   logic [8:0] q_m;
   logic [3:0] n1q;

   logic [8:0] q_m_r;
   logic [3:0] n1q_r;
   logic       de_r;
   logic [1:0] ctrl_r;

   // Choose XOR/XNOR chain from the input ones count and build q_m.
   always_comb begin
      n1d = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         n1d = n1d + {3'b000, link.din[i]};
      end
      use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !link.din[0]);
      q_m      = '0;
      q_m[0]   = link.din[0];
      for (int unsigned i = 1; i < 8; i++) begin
         q_m[i] = use_xnor ? ~(q_m[i-1] ^ link.din[i]) : (q_m[i-1] ^ link.din[i]);
      end
      q_m[8] = ~use_xnor;
      n1q    = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         n1q = n1q + {3'b000, q_m[i]};
      end
   end

   // Stage-1 pipeline register.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         q_m_r  <= '0;
         n1q_r  <= '0;
         de_r   <= 1'b0;
         ctrl_r <= '0;
      end else begin
         q_m_r  <= q_m;
         n1q_r  <= n1q;
         de_r   <= link.de;
         ctrl_r <= link.ctrl;
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2: DC balance
   // ---------------------------------------------------------------------
   logic signed [4:0] cnt;
   logic signed [4:0] cnt_next;
   logic signed [5:0] cnt_ext;
   logic signed [5:0] cnt_sum;
   logic signed [5:0] n1s;
   logic signed [5:0] n0s;
   mode_t             mode;
   logic [9:0]        sym;

   // Pick the encoding mode, form the symbol and the next disparity.
   always_comb begin
      n1s     = $signed({2'b00, n1q_r});
      n0s     = 6'sd8 - n1s;
      cnt_ext = {cnt[4], cnt};
      cnt_sum = '0;
      sym     = CTRL_TOKEN_00;

      if (!de_r) begin
         mode = MODE_CTRL;
      end else if ((cnt == 5'sd0) || (n1q_r == 4'd4)) begin
         mode = MODE_BAL;
      end else if ((!cnt[4] && (n1q_r > 4'd4)) || (cnt[4] && (n1q_r < 4'd4))) begin
         mode = MODE_INV;
      end else begin
         mode = MODE_PASS;
      end

      unique case (mode)
         MODE_CTRL: begin
            unique case (ctrl_r)
               2'b00: sym = CTRL_TOKEN_00;
               2'b01: sym = CTRL_TOKEN_01;
               2'b10: sym = CTRL_TOKEN_10;
               2'b11: sym = CTRL_TOKEN_11;
            endcase
            cnt_sum = '0;
         end
         MODE_BAL: begin
            sym = {~q_m_r[8], q_m_r[8], q_m_r[8] ? q_m_r[7:0] : ~q_m_r[7:0]};
            if (q_m_r[8]) begin
               cnt_sum = cnt_ext + (n1s - n0s);
            end else begin
               cnt_sum = cnt_ext + (n0s - n1s);
            end
         end
         MODE_INV: begin
            sym     = {1'b1, q_m_r[8], ~q_m_r[7:0]};
            cnt_sum = cnt_ext + (q_m_r[8] ? 6'sd2 : 6'sd0) + (n0s - n1s);
         end
         MODE_PASS: begin
            sym     = {1'b0, q_m_r[8], q_m_r[7:0]};
            cnt_sum = cnt_ext - (q_m_r[8] ? 6'sd0 : 6'sd2) + (n1s - n0s);
         end
      endcase

      cnt_next = cnt_sum[4:0];
   end

   // Output delay line; index 0 is the stage-2 register itself.
   logic [9:0] tmds_pipe [0:LATENCY_ALIGN];
   logic       de_pipe   [0:LATENCY_ALIGN];

   // Stage-2 register: symbol, aligned data enable and running disparity.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         tmds_pipe[0] <= CTRL_TOKEN_00;
         de_pipe[0]   <= 1'b0;
         cnt          <= '0;
      end else begin
         tmds_pipe[0] <= sym;
         de_pipe[0]   <= de_r;
         cnt          <= cnt_next;
      end
   end

   genvar k;
   for (k = 1; k <= LATENCY_ALIGN; k++) begin : g_align
      // Delay-matching stage, reset to the same idle token as stage 2.
      always_ff @(posedge sysclk) begin
         if (rst) begin
            tmds_pipe[k] <= CTRL_TOKEN_00;
            de_pipe[k]   <= 1'b0;
         end else begin
            tmds_pipe[k] <= tmds_pipe[k-1];
            de_pipe[k]   <= de_pipe[k-1];
         end
      end
   end

   assign link.tmds   = tmds_pipe[LATENCY_ALIGN];
   assign link.de_out = de_pipe[LATENCY_ALIGN];

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Bench for tmds_channel_encoder: fixed vector table, hand-written reset
// sequence, and randomized traffic checked against a behavioural model.
module tb_tmds_channel_encoder;

   localparam int unsigned LA   = 0;
   localparam int          MAXC = 16000;
   localparam logic [9:0]  TOK0 = 10'b1101010100;

   logic sysclk = 1'b0;
   logic rst;

   tmds_channel_encoder_if link();

   tmds_channel_encoder #(.LATENCY_ALIGN(LA)) dut (
      .sysclk (sysclk),
      .rst    (rst),
      .link   (link)
   );

   always #5 sysclk = ~sysclk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Per-edge history of applied inputs and modelled stage-2 results.
   logic       h_rst  [MAXC];
   logic       h_de   [MAXC];
   logic [7:0] h_din  [MAXC];
   logic [1:0] h_ctrl [MAXC];
   logic [9:0] s2_sym [MAXC];
   logic       s2_de  [MAXC];

   int model_disp = 0;   // disparity of symbols the model has emitted
   int dut_disp   = 0;   // disparity of bits actually emitted by the DUT

   typedef struct {
      logic       de;
      logic [7:0] din;
      logic [1:0] ctrl;
      logic [9:0] exp_tmds;
      logic       exp_de;
   } vec_t;

   vec_t tbl[14];

   function automatic int pop(input logic [9:0] v);
      int n = 0;
      for (int i = 0; i < 10; i++) n += int'(v[i]);
      return n;
   endfunction

   function automatic logic [9:0] ctrl_token(input logic [1:0] c);
      case (c)
         2'b00:   return 10'b1101010100;
         2'b01:   return 10'b0010101011;
         2'b10:   return 10'b0101010100;
         default: return 10'b1010101011;
      endcase
   endfunction

   // Encode one byte given the current disparity; new disparity is derived
   // from the ones/zeros balance of the emitted 10-bit symbol.
   function automatic logic [9:0] ref_encode(input logic [7:0] d, input int disp, output int nd);
      int         n1;
      int         ones;
      logic       xn;
      logic       inv;
      logic [7:0] q;
      logic [9:0] s;
      n1   = pop({2'b00, d});
      xn   = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      q    = '0;
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      ones = pop({2'b00, q});
      if (disp == 0 || ones == 4) inv = xn;
      else                        inv = ((disp > 0) == (ones > 4));
      s  = {inv, ~xn, inv ? ~q : q};
      nd = disp + 2 * pop(s) - 10;
      return s;
   endfunction

   function automatic logic [7:0] ref_decode(input logic [9:0] s);
      logic [7:0] q;
      logic [7:0] d;
      q    = s[9] ? ~s[7:0] : s[7:0];
      d    = '0;
      d[0] = q[0];
      for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      return d;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   // Apply one cycle of inputs, advance the model, compare the DUT output.
   task automatic step(input logic r, input logic d, input logic [7:0] x, input logic [1:0] c);
      int         nd;
      bit         rst_win;
      logic [9:0] exp_sym;
      logic       exp_de;
      if (cyc >= MAXC) begin
         $display("FAIL cycle_budget cycle=%0d got=overflow want=<%0d", cyc, MAXC);
         $fatal(1);
      end
      rst       = r;
      link.de   = d;
      link.din  = x;
      link.ctrl = c;
      @(posedge sysclk);
      h_rst[cyc]  = r;
      h_de[cyc]   = d;
      h_din[cyc]  = x;
      h_ctrl[cyc] = c;
      if (r || cyc == 0 || h_rst[cyc-1]) begin
         s2_sym[cyc] = TOK0;
         s2_de[cyc]  = 1'b0;
         model_disp  = 0;
      end else if (!h_de[cyc-1]) begin
         s2_sym[cyc] = ctrl_token(h_ctrl[cyc-1]);
         s2_de[cyc]  = 1'b0;
         model_disp  = 0;
      end else begin
         s2_sym[cyc] = ref_encode(h_din[cyc-1], model_disp, nd);
         s2_de[cyc]  = 1'b1;
         model_disp  = nd;
      end
      rst_win = (cyc < int'(LA));
      for (int j = cyc - int'(LA) + 1; j <= cyc; j++) begin
         if (j >= 0 && h_rst[j]) rst_win = 1'b1;
      end
      if (rst_win) begin
         exp_sym = TOK0;
         exp_de  = 1'b0;
      end else begin
         exp_sym = s2_sym[cyc - int'(LA)];
         exp_de  = s2_de[cyc - int'(LA)];
      end
      #1;
      chk("model", {21'd0, link.de_out, link.tmds}, {21'd0, exp_de, exp_sym});
      if (exp_de) begin
         chk("decode", {24'd0, ref_decode(link.tmds)}, {24'd0, h_din[cyc - int'(LA) - 1]});
      end
      if (link.de_out) begin
         dut_disp = dut_disp + 2 * pop(link.tmds) - 10;
         chk("disparity_bound", {31'd0, (dut_disp > 10 || dut_disp < -10)}, 32'd0);
      end else begin
         dut_disp = 0;
      end
      cyc++;
   endtask

   logic de_m;

   initial begin
      tbl[0]  = '{1'b0, 8'h00, 2'b00, 10'h354, 1'b0};
      tbl[1]  = '{1'b0, 8'h00, 2'b01, 10'h354, 1'b0};
      tbl[2]  = '{1'b0, 8'h00, 2'b10, 10'h0AB, 1'b0};
      tbl[3]  = '{1'b0, 8'h00, 2'b11, 10'h154, 1'b0};
      tbl[4]  = '{1'b1, 8'h00, 2'b00, 10'h2AB, 1'b0};
      tbl[5]  = '{1'b1, 8'h00, 2'b00, 10'h100, 1'b1};
      tbl[6]  = '{1'b1, 8'h55, 2'b00, 10'h3FF, 1'b1};
      tbl[7]  = '{1'b1, 8'h55, 2'b00, 10'h133, 1'b1};
      tbl[8]  = '{1'b0, 8'h00, 2'b00, 10'h133, 1'b1};
      tbl[9]  = '{1'b1, 8'h00, 2'b00, 10'h354, 1'b0};
      tbl[10] = '{1'b1, 8'h00, 2'b00, 10'h100, 1'b1};
      tbl[11] = '{1'b0, 8'h00, 2'b00, 10'h3FF, 1'b1};
      tbl[12] = '{1'b1, 8'h55, 2'b00, 10'h354, 1'b0};
      tbl[13] = '{1'b0, 8'h00, 2'b00, 10'h133, 1'b1};

      // Reset held with random inputs.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'($urandom), 8'($urandom), 2'($urandom));
         chk("reset", {21'd0, link.de_out, link.tmds}, {21'd0, 1'b0, TOK0});
      end

      // Control tokens, disparity from zero, balanced input, de edges.
      for (int i = 0; i < 14; i++) begin
         step(1'b0, tbl[i].de, tbl[i].din, tbl[i].ctrl);
         chk($sformatf("tbl[%0d]", i), {21'd0, link.de_out, link.tmds},
             {21'd0, tbl[i].exp_de, tbl[i].exp_tmds});
      end

      // Mid-stream reset during a data burst.
      step(1'b0, 1'b1, 8'h00, 2'b00);
      step(1'b0, 1'b1, 8'h00, 2'b00);
      step(1'b1, 1'b1, 8'hA5, 2'b00);
      chk("mid_rst_0", {21'd0, link.de_out, link.tmds}, {21'd0, 1'b0, TOK0});
      step(1'b0, 1'b1, 8'h00, 2'b00);
      chk("mid_rst_1", {21'd0, link.de_out, link.tmds}, {21'd0, 1'b0, TOK0});
      step(1'b0, 1'b1, 8'h00, 2'b00);
      chk("resume_0", {21'd0, link.de_out, link.tmds}, {21'd0, 1'b1, 10'h100});
      step(1'b0, 1'b1, 8'hA5, 2'b00);
      chk("resume_1", {21'd0, link.de_out, link.tmds}, {21'd0, 1'b1, 10'h3FF});

      // DC balance soak.
      for (int i = 0; i < 10000; i++) begin
         step(1'b0, 1'b1, 8'($urandom), 2'($urandom));
      end

      // Mixed control/data periods with occasional resets.
      de_m = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) de_m = ~de_m;
         step(($urandom_range(0, 199) == 0), de_m, 8'($urandom), 2'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
